// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// InstFetch -- instruction fetch unit with a single-entry instruction register
//
// Sends a byte address to a combinational big-endian instruction memory and
// captures the returned word into IR. IR is handed downstream with a
// valid/ready handshake. Three states:
//   RUN   : fetching normally
//   HALT  : entered after loading a word whose opcode is 6'b111111
//   FAULT : entered on a fetch from a misaligned or out-of-range pc; only
//           Reset leaves it
//
// Ports
//   CLK          in   clock, all registers update on the rising edge
//   Reset        in   synchronous active-high reset
//   pc           out  [31:0] byte address to instruction memory
//   InsMemRW     out  0 = memory read enabled, 1 = memory output forced to 0
//   inst_in      in   [31:0] word returned by memory for pc
//   redirect     in   branch/jump redirect request
//   redirect_pc  in   [31:0] redirect target
//   IR           out  [31:0] instruction register
//   ir_pc        out  [31:0] address of the instruction in IR
//   ir_valid     out  IR holds an unconsumed instruction
//   ir_ready     in   downstream accepts IR this cycle
//   fault        out  sticky fetch fault
//   halted       out  block is in HALT
//
// Optional feature: define INST_FETCH_PERF_EN to add the performance counters
//   fetch_count  out  [31:0] number of successful IR loads
//   stall_count  out  [31:0] RUN cycles with IR held by downstream
// ---------------------------------------------------------------------------
module inst_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] ADDR_LIMIT = 32'd100
) (
    input  logic        CLK,
    input  logic        Reset,
    output logic [31:0] pc,
    output logic        InsMemRW,
    input  logic [31:0] inst_in,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] IR,
    output logic [31:0] ir_pc,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic        fault,
    output logic        halted
`ifdef INST_FETCH_PERF_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
`endif
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HALT  = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam logic [5:0] HALT_OPCODE = 6'b111111;

    state_t state;
    state_t state_next;
    logic   take_redirect;
    logic   load;
    logic   fault_hit;
    logic   pc_illegal;

    // The upper-bound test is widened to 33 bits so that a pc near 2^32
    // cannot wrap around and look legal.
    assign pc_illegal = (pc[1:0] != 2'b00) ||
                        (({1'b0, pc} + 33'd3) > {1'b0, ADDR_LIMIT});

    // Memory is disabled whenever no fetch can happen, including during reset.
    assign InsMemRW = Reset || (state != RUN);
    assign halted   = (state == HALT);

    // State register.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and per-cycle action decode. A redirect pre-empts the
    // fetch slot; FAULT ignores everything until reset.
    always_comb begin
        state_next    = state;
        take_redirect = 1'b0;
        load          = 1'b0;
        fault_hit     = 1'b0;
        case (state)
            RUN: begin
                if (redirect) begin
                    take_redirect = 1'b1;
                end else if (!ir_valid || ir_ready) begin
                    if (pc_illegal) begin
                        fault_hit  = 1'b1;
                        state_next = FAULT;
                    end else begin
                        load = 1'b1;
                        if (inst_in[31:26] == HALT_OPCODE) begin
                            state_next = HALT;
                        end
                    end
                end
            end
            HALT: begin
                if (redirect) begin
                    take_redirect = 1'b1;
                    state_next    = RUN;
                end
            end
            FAULT: begin
                state_next = FAULT;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // Datapath. A consumed IR with no replacement load simply goes invalid;
    // a redirect drops IR whether or not downstream took it this cycle.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            pc       <= RESET_PC;
            IR       <= 32'h0;
            ir_pc    <= 32'h0;
            ir_valid <= 1'b0;
            fault    <= 1'b0;
        end else if (take_redirect) begin
            pc       <= redirect_pc;
            ir_valid <= 1'b0;
        end else if (load) begin
            IR       <= inst_in;
            ir_pc    <= pc;
            ir_valid <= 1'b1;
            pc       <= pc + 32'd4;
        end else if (fault_hit) begin
            ir_valid <= 1'b0;
            fault    <= 1'b1;
        end else if (ir_valid && ir_ready) begin
            ir_valid <= 1'b0;
        end
    end

`ifdef INST_FETCH_PERF_EN
    // Performance counters, free-running modulo 2^32.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            fetch_count <= 32'h0;
            stall_count <= 32'h0;
        end else begin
            if (load) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if ((state == RUN) && ir_valid && !ir_ready) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch -- self-checking bench for inst_fetch
//
// Holds a byte-addressed big-endian instruction memory and a behavioural
// model of the fetch unit. Directed scenarios walk through reset, stalls,
// redirects, halt, fault and the address limit; a random phase follows.
// Every cycle all outputs are compared with the model; directed scenarios
// add fixed expected values on top. Define INST_FETCH_PERF_EN to include
// the performance counters.
// ---------------------------------------------------------------------------
module tb_inst_fetch;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] ADDR_LIMIT = 32'd100;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [31:0] pc;
    logic        InsMemRW;
    logic [31:0] inst_in;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] IR;
    logic [31:0] ir_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic        fault;
    logic        halted;
`ifdef INST_FETCH_PERF_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    int checkCount = 0;
    int failCount  = 0;

    // Instruction memory: bytes, big-endian words.
    logic [7:0] mem [0:127];

    // Reference model state.
    logic [31:0] mPc;
    logic [31:0] mIr;
    logic [31:0] mIrPc;
    logic        mValid;
    logic        mFault;
    logic        mHalted;
    logic [31:0] mFetches;
    logic [31:0] mStalls;

    inst_fetch #(
        .RESET_PC   (RESET_PC),
        .ADDR_LIMIT (ADDR_LIMIT)
    ) dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .pc          (pc),
        .InsMemRW    (InsMemRW),
        .inst_in     (inst_in),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .IR          (IR),
        .ir_pc       (ir_pc),
        .ir_valid    (ir_valid),
        .ir_ready    (ir_ready),
        .fault       (fault),
        .halted      (halted)
`ifdef INST_FETCH_PERF_EN
        ,
        .fetch_count (fetch_count),
        .stall_count (stall_count)
`endif
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        if (addr > 32'd124) begin
            return 32'h0;
        end
        return {mem[addr], mem[addr + 1], mem[addr + 2], mem[addr + 3]};
    endfunction

    assign inst_in = InsMemRW ? 32'h0 : memWord(pc);

    task automatic storeWord(input logic [31:0] addr, input logic [31:0] word);
        mem[addr]     = word[31:24];
        mem[addr + 1] = word[23:16];
        mem[addr + 2] = word[15:8];
        mem[addr + 3] = word[7:0];
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // One clock of the behavioural model, using the inputs about to be sampled.
    task automatic modelStep();
        logic [63:0] lastByte;
        if (Reset) begin
            mPc      = RESET_PC;
            mIr      = 32'h0;
            mIrPc    = 32'h0;
            mValid   = 1'b0;
            mFault   = 1'b0;
            mHalted  = 1'b0;
            mFetches = 32'h0;
            mStalls  = 32'h0;
        end else if (!mFault) begin
            if (!mHalted && mValid && !ir_ready) begin
                mStalls = mStalls + 1;
            end
            if (redirect) begin
                mPc     = redirect_pc;
                mValid  = 1'b0;
                mHalted = 1'b0;
            end else if (!mHalted && (!mValid || ir_ready)) begin
                lastByte = {32'h0, mPc} + 64'd3;
                if ((mPc % 4 != 0) || (lastByte > {32'h0, ADDR_LIMIT})) begin
                    mValid = 1'b0;
                    mFault = 1'b1;
                end else begin
                    mIr      = memWord(mPc);
                    mIrPc    = mPc;
                    mValid   = 1'b1;
                    mPc      = mPc + 32'd4;
                    mFetches = mFetches + 1;
                    if (mIr[31:26] == 6'b111111) begin
                        mHalted = 1'b1;
                    end
                end
            end else if (mValid && ir_ready) begin
                mValid = 1'b0;
            end
        end
    endtask

    task automatic compareModel();
        checkOutput("pc", pc, mPc);
        checkOutput("IR", IR, mIr);
        checkOutput("ir_pc", ir_pc, mIrPc);
        checkOutput("ir_valid", {31'h0, ir_valid}, {31'h0, mValid});
        checkOutput("fault", {31'h0, fault}, {31'h0, mFault});
        checkOutput("halted", {31'h0, halted}, {31'h0, mHalted});
        checkOutput("InsMemRW", {31'h0, InsMemRW},
                    {31'h0, (Reset || mFault || mHalted)});
`ifdef INST_FETCH_PERF_EN
        checkOutput("fetch_count", fetch_count, mFetches);
        checkOutput("stall_count", stall_count, mStalls);
`endif
    endtask

    // Drive one cycle of inputs on the falling edge, then check after the
    // rising edge.
    task automatic applyStimulus(input logic rst, input logic rdr,
                                 input logic [31:0] rdrPc, input logic rdy);
        @(negedge CLK);
        Reset       = rst;
        redirect    = rdr;
        redirect_pc = rdrPc;
        ir_ready    = rdy;
        modelStep();
        @(posedge CLK);
        #1;
        compareModel();
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] target;
        Reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        ir_ready    = 1'b1;

        for (int a = 0; a < 128; a += 4) begin
            storeWord(a, 32'h0100_0000 + a);
        end
        storeWord(32'd12, 32'hFC00_0000);

        // Reset state with reset still asserted.
        doReset();
        checkOutput("rst_pc", pc, RESET_PC);
        checkOutput("rst_valid", {31'h0, ir_valid}, 32'h0);
        checkOutput("rst_memrw", {31'h0, InsMemRW}, 32'h1);

        // Back-to-back fetches from reset release.
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("rel_irpc0", ir_pc, 32'h0);
        checkOutput("rel_ir0", IR, 32'h0100_0000);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("rel_irpc4", ir_pc, 32'h4);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("rel_irpc8", ir_pc, 32'h8);
        checkOutput("rel_ir8", IR, 32'h0100_0008);

        // Downstream stall on the word at 4.
        doReset();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
            checkOutput("stall_irpc", ir_pc, 32'h4);
            checkOutput("stall_pc", pc, 32'h8);
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("resume_irpc", ir_pc, 32'h8);

        // Redirect while IR is held.
        applyStimulus(1'b0, 1'b1, 32'h20, 1'b0);
        checkOutput("rdr_valid", {31'h0, ir_valid}, 32'h0);
        checkOutput("rdr_pc", pc, 32'h20);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("rdr_irpc", ir_pc, 32'h20);

        // Halt opcode at 12, then restart by redirect.
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        end
        checkOutput("halt_ir", IR, 32'hFC00_0000);
        checkOutput("halt_flag", {31'h0, halted}, 32'h1);
        checkOutput("halt_memrw", {31'h0, InsMemRW}, 32'h1);
        checkOutput("halt_pc", pc, 32'h10);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("halt_pc_hold", pc, 32'h10);
        checkOutput("halt_consumed", {31'h0, ir_valid}, 32'h0);
        applyStimulus(1'b0, 1'b1, 32'h0, 1'b1);
        checkOutput("unhalt", {31'h0, halted}, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("unhalt_irpc", ir_pc, 32'h0);

        // Misaligned redirect target faults; fault is sticky.
        applyStimulus(1'b0, 1'b1, 32'h62, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("flt_fault", {31'h0, fault}, 32'h1);
        checkOutput("flt_valid", {31'h0, ir_valid}, 32'h0);
        applyStimulus(1'b0, 1'b1, 32'h0, 1'b1);
        checkOutput("flt_ignore_pc", pc, 32'h62);
        checkOutput("flt_sticky", {31'h0, fault}, 32'h1);
        doReset();
        checkOutput("flt_cleared", {31'h0, fault}, 32'h0);

        // Address limit: word at 96 ends at byte 99 (legal), 100 does not fit.
        applyStimulus(1'b0, 1'b1, 32'd96, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("lim_96_irpc", ir_pc, 32'd96);
        checkOutput("lim_96_ok", {31'h0, fault}, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("lim_100_fault", {31'h0, fault}, 32'h1);
        checkOutput("lim_100_pc", pc, 32'd100);

`ifdef INST_FETCH_PERF_EN
        // Five fetches and two stall cycles from a fresh reset.
        doReset();
        applyStimulus(1'b0, 1'b1, 32'h20, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("perf_fetch", fetch_count, 32'd5);
        checkOutput("perf_stall", stall_count, 32'd2);
`endif

        // Random phase with occasional halt opcodes in memory.
        for (int a = 0; a < 128; a += 4) begin
            w = $urandom;
            if ($urandom_range(11) == 0) begin
                w[31:26] = 6'b111111;
            end else if (w[31:26] == 6'b111111) begin
                w[31:26] = 6'b000000;
            end
            storeWord(a, w);
        end
        doReset();
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(9))
                0:       target = $urandom;
                1:       target = $urandom_range(110);
                default: target = 4 * $urandom_range(26);
            endcase
            applyStimulus(($urandom_range(63) == 0),
                          ($urandom_range(7) == 0),
                          target,
                          ($urandom_range(9) < 7));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checkCount, failCount);
        $finish;
    end

endmodule
